median_window_ctrl: RTL and testbench
=====================================

# median_window_ctrl

Frame-level sequencer for the 3x3 median sorter. Accepts a raster-order 8-bit grayscale pixel stream and keeps two line buffers plus a 3x3 window register. For every interior pixel it issues one window per cycle to the 9-input median sorter, then realigns the returned median with a valid flag. It sits between the pixel source and the sorter and owns frame start, fill, run and drain sequencing.

## Interface
- `IMG_W`, default 64: pixels per line, at least 3.
- `IMG_H`, default 64: lines per frame, at least 3.
- `PIPE_LAT`, default 10: sorter latency in clock edges, from `win_px*` sampled to `med_in` valid.
- `clk` in, 1: single clock, rising edge.
- `nres` in, 1: asynchronous active-low reset.
- `in_valid` in, 1: source pixel valid.
- `in_ready` out, 1: controller can accept a pixel.
- `in_pixel` in, 8: source pixel.
- `in_sof` in, 1: qualifies the accepted pixel as (row 0, col 0).
- `win_px0`..`win_px8` out, 8 each: window to the sorter. Row-major, top row first, left to right. `win_px4` is the center.
- `win_valid` out, 1: window registers hold a new interior window.
- `sort_en` out, 1: sorter enable.
- `med_in` in, 8: median returned by the sorter.
- `out_valid` out, 1: one-cycle pulse per filtered pixel.
- `out_pixel` out, 8: filtered pixel.
- `frame_done` out, 1: one-cycle pulse after the last output of a frame.
- `frame_abort` out, 1: one-cycle pulse when `in_sof` arrives mid-frame.

## Operation
- Reset value of all outputs is 0, except `in_ready`, which resets to 1.
- Reset clears the counters, the valid shift register and the state.
- Line buffer and window contents are don't-care after reset.
- A pixel is accepted on a rising edge with `in_valid && in_ready`.
- States:
  - IDLE: `in_ready`=1. Pixels without `in_sof` are discarded. An accepted pixel with `in_sof` sets col=1, row=0 and moves to FILL.
  - FILL: rows 0-1 are written to the line buffers and no windows are issued. Leaves for RUN when the accepted pixel reaches row 2, col 0.
  - RUN: each accepted pixel at (r,c) shifts column {lb1[c], lb0[c], pixel} into the window. Then lb1[c]<=lb0[c] and lb0[c]<=pixel.
    - When c>=2, `win_valid` pulses and the window's center is pixel (r-1,c-1).
    - Accepting (IMG_H-1, IMG_W-1) moves to DRAIN.
  - DRAIN: `in_ready`=0. The block waits until the valid shift register is empty, pulses `frame_done`, then returns to IDLE.
- Column/row counters wrap: col IMG_W-1 goes to 0 and row increments.
- `sort_en`=1 in every state except IDLE.
- Latency alignment: a PIPE_LAT-deep shift register carries `win_valid`. On its output, `out_pixel` is registered from `med_in` and `out_valid` is set.
- Exactly (IMG_W-2)*(IMG_H-2) `out_valid` pulses occur per completed frame, in raster order. Border pixels produce no output.
- An accepted `in_sof` in FILL or RUN does the following:
  - pulses `frame_abort`;
  - clears the valid shift register, so in-flight windows produce no output;
  - restarts the frame with that pixel at (0,0) in FILL.
- `in_sof` is ignored in DRAIN because `in_ready`=0.
- Gaps (`in_valid`=0) stall the counters and window. Issued windows keep draining regardless.

## Timing
- Pixel accepted at edge T: window update and `win_valid` at edge T+1.
- `med_in` is valid after edge T+1+PIPE_LAT.
- `out_valid`/`out_pixel` are registered at edge T+2+PIPE_LAT, which is 12 edges with default settings.
- Throughput is one pixel per cycle in FILL and RUN.
- `frame_done` is asserted on the edge after the last `out_valid` of the frame.
- `frame_abort` is asserted at the edge after the aborting acceptance.
- The next frame may be accepted on the cycle `frame_done` is high, since the block is back in IDLE.
- `nres` low mid-frame: outputs go to reset values immediately, with no `frame_done` and no `frame_abort`.

## Configuration
- `NOISE_GATE_EN` defined:
  - The window center `win_px4` travels with the valid bit through a PIPE_LAT-deep byte delay line.
  - `out_pixel` = `med_in` only when the delayed center is 8'h00 or 8'hFF. Otherwise it is the delayed center unchanged.
  - Timing and valid behaviour are identical to the undefined case.
- `NOISE_GATE_EN` undefined: `out_pixel` is always `med_in`, and the delay line is absent.

## Test plan
- IMG_W=5, IMG_H=4, ramp pixel value = 10*row+col, gap-free, sorter model returns the true median:
  - exactly 6 outputs: 11,12,13,21,22,23;
  - first `out_valid` 12 edges after (2,2) is accepted;
  - `frame_done` one edge after the last output.
- All pixels 8'h80 except (1,1)=8'hFF: output at center (1,1) is 8'h80, with or without `NOISE_GATE_EN`.
- With `NOISE_GATE_EN`, all pixels 8'h40 except (2,2)=8'h41: output at (2,2) is 8'h41 (center passed, not the median 8'h40).
- `in_valid` toggling 1/0 every cycle on the ramp frame: identical output values and count, with each output 12 edges after its triggering pixel is accepted.
- `in_sof` re-asserted at (2,3) of a frame: `frame_abort` pulses and no stale outputs appear. The restarted frame yields exactly 6 correct outputs and one `frame_done`.
- `nres` pulsed low during DRAIN: all outputs return to reset values immediately and no `frame_done` occurs. The next frame then processes normally.

Source files
------------

// File: rtl/median_window_ctrl.sv
// median_window_ctrl
// Frame sequencer in front of a 3x3 median sorter. Accepts a raster-order
// 8-bit pixel stream, keeps two line buffers and a 3x3 window, issues one
// window per interior pixel and realigns the returned median with a valid.
//
// Optional feature: define NOISE_GATE_EN to replace the median by the
// delayed window centre unless that centre is 8'h00 or 8'hFF.
//
// Ports:
//   clk, nres               clock, asynchronous active-low reset
//   in_valid/in_ready       source handshake, in_pixel data, in_sof = (0,0)
//   win_px0..win_px8        window to sorter, row-major, win_px4 = centre
//   win_valid, sort_en      new interior window / sorter enable
//   med_in                  median returned PIPE_LAT edges after window
//   out_valid, out_pixel    filtered pixel stream
//   frame_done, frame_abort end-of-frame / mid-frame restart pulses
module median_window_ctrl #(
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 64,
  parameter int unsigned PIPE_LAT = 10
) (
  input  logic       clk,
  input  logic       nres,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pixel,
  input  logic       in_sof,
  output logic [7:0] win_px0,
  output logic [7:0] win_px1,
  output logic [7:0] win_px2,
  output logic [7:0] win_px3,
  output logic [7:0] win_px4,
  output logic [7:0] win_px5,
  output logic [7:0] win_px6,
  output logic [7:0] win_px7,
  output logic [7:0] win_px8,
  output logic       win_valid,
  output logic       sort_en,
  input  logic [7:0] med_in,
  output logic       out_valid,
  output logic [7:0] out_pixel,
  output logic       frame_done,
  output logic       frame_abort
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_e;

  state_e        state_q;
  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  logic          in_ready_q, sort_en_q, frame_done_q, frame_abort_q, abort_q;
  logic          acc, take, abort, last_px;

  // Pixel stage: captures the accepted pixel and its position.
  logic          pend_q;
  logic [7:0]    ppix_q;
  logic [CW-1:0] pcol_q;
  logic [RW-1:0] prow_q;

  logic [7:0]    win_q [9];
  logic          win_valid_q;
  logic [PIPE_LAT-1:0] vsr_q;
  logic          out_valid_q;
  logic [7:0]    out_pixel_q, out_sel;

  logic [7:0]    lb0_q [IMG_W];
  logic [7:0]    lb1_q [IMG_W];

  always_comb begin
    acc     = in_valid && in_ready_q;
    abort   = acc && in_sof && (state_q == FILL || state_q == RUN);
    take    = acc && (state_q != IDLE || in_sof);
    pos_col = in_sof ? '0 : col_q;
    pos_row = in_sof ? '0 : row_q;
    if (in_sof) begin
      col_d = CW'(1);
      row_d = '0;
    end else if (col_q == CW'(IMG_W - 1)) begin
      col_d = '0;
      row_d = row_q + RW'(1);
    end else begin
      col_d = col_q + CW'(1);
      row_d = row_q;
    end
    last_px = (pos_row == RW'(IMG_H - 1)) && (pos_col == CW'(IMG_W - 1));
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      in_ready_q    <= 1'b1;
      sort_en_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      abort_q       <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      abort_q       <= abort;
      frame_abort_q <= abort_q;
      if (take) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      case (state_q)
        IDLE: if (take) begin
          state_q   <= FILL;
          sort_en_q <= 1'b1;
        end
        FILL, RUN: begin
          if (abort) begin
            state_q <= FILL;
          end else if (take && last_px) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end else if (take && state_q == FILL && row_d == RW'(2) && col_d == '0) begin
            state_q <= RUN;
          end
        end
        DRAIN: begin
          // Wait until no pixel, window or valid bit is still in flight.
          if (!pend_q && !win_valid_q && vsr_q == '0) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            sort_en_q    <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      pend_q      <= 1'b0;
      ppix_q      <= '0;
      pcol_q      <= '0;
      prow_q      <= '0;
      win_valid_q <= 1'b0;
      vsr_q       <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      for (int unsigned i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      pend_q <= take;
      if (take) begin
        ppix_q <= in_pixel;
        pcol_q <= pos_col;
        prow_q <= pos_row;
      end
      if (pend_q) begin
        win_q[0] <= win_q[1]; win_q[1] <= win_q[2]; win_q[2] <= lb1_q[pcol_q];
        win_q[3] <= win_q[4]; win_q[4] <= win_q[5]; win_q[5] <= lb0_q[pcol_q];
        win_q[6] <= win_q[7]; win_q[7] <= win_q[8]; win_q[8] <= ppix_q;
      end
      // An abort kills the pixel still in the capture stage and every
      // window already issued, so nothing from the old frame reaches out_*.
      win_valid_q <= pend_q && !abort && prow_q >= RW'(2) && pcol_q >= CW'(2);
      vsr_q       <= abort ? '0 : {vsr_q[PIPE_LAT-2:0], win_valid_q};
      out_valid_q <= vsr_q[PIPE_LAT-1] && !abort;
      if (vsr_q[PIPE_LAT-1] && !abort) out_pixel_q <= out_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (pend_q) begin
      lb1_q[pcol_q] <= lb0_q[pcol_q];
      lb0_q[pcol_q] <= ppix_q;
    end
  end

`ifdef NOISE_GATE_EN
  logic [7:0] cen_q [PIPE_LAT];

  always_ff @(posedge clk) begin
    cen_q[0] <= win_q[4];
    for (int unsigned i = 1; i < PIPE_LAT; i++) cen_q[i] <= cen_q[i-1];
  end

  always_comb begin
    out_sel = cen_q[PIPE_LAT-1];
    if (cen_q[PIPE_LAT-1] == 8'h00 || cen_q[PIPE_LAT-1] == 8'hFF) out_sel = med_in;
  end
`else
  always_comb out_sel = med_in;
`endif

  assign in_ready    = in_ready_q;
  assign sort_en     = sort_en_q;
  assign win_valid   = win_valid_q;
  assign out_valid   = out_valid_q;
  assign out_pixel   = out_pixel_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign win_px0 = win_q[0];
  assign win_px1 = win_q[1];
  assign win_px2 = win_q[2];
  assign win_px3 = win_q[3];
  assign win_px4 = win_q[4];
  assign win_px5 = win_q[5];
  assign win_px6 = win_q[6];
  assign win_px7 = win_q[7];
  assign win_px8 = win_q[8];
endmodule

// File: tb/tb_median_window_ctrl.sv
// Self-checking bench for median_window_ctrl on a 5x4 frame with a
// behavioural sorter returning the true median PIPE_LAT edges later.
module tb_median_window_ctrl;
  localparam int unsigned W = 5, H = 4, LAT = 10;

  logic clk, nres, in_valid, in_ready, in_sof;
  logic [7:0] in_pixel, med_in, out_pixel;
  logic [7:0] win_px0, win_px1, win_px2, win_px3, win_px4, win_px5, win_px6, win_px7, win_px8;
  logic win_valid, sort_en, out_valid, frame_done, frame_abort;

  int unsigned checks = 0, errors = 0, cyc = 0;
  int unsigned out_cnt, done_cnt, abort_cnt, last_out_cyc, done_cyc, abort_cyc;

  typedef struct { logic [7:0] val; int unsigned cyc; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] got[$];
  logic [7:0] img [H][W];
  logic [7:0] ramp_exp [6] = '{8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd23};

  typedef struct { int unsigned pat; bit gap; int unsigned n_out; int unsigned pidx; logic [7:0] pval; } vec_t;
  vec_t vecs [4];

`ifdef NOISE_GATE_EN
  localparam logic [7:0] P3 = 8'h41;
`else
  localparam logic [7:0] P3 = 8'h40;
`endif

  median_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(LAT)) dut (
    .clk(clk), .nres(nres), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sof(in_sof),
    .win_px0(win_px0), .win_px1(win_px1), .win_px2(win_px2),
    .win_px3(win_px3), .win_px4(win_px4), .win_px5(win_px5),
    .win_px6(win_px6), .win_px7(win_px7), .win_px8(win_px8),
    .win_valid(win_valid), .sort_en(sort_en), .med_in(med_in),
    .out_valid(out_valid), .out_pixel(out_pixel),
    .frame_done(frame_done), .frame_abort(frame_abort));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] med9(input logic [7:0] a [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = a;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s[4];
  endfunction

  // Sorter model: median of the presented window, PIPE_LAT edges later.
  logic [7:0] wa [9];
  logic [7:0] med_pipe [LAT];
  always_comb begin
    wa[0] = win_px0; wa[1] = win_px1; wa[2] = win_px2;
    wa[3] = win_px3; wa[4] = win_px4; wa[5] = win_px5;
    wa[6] = win_px6; wa[7] = win_px7; wa[8] = win_px8;
  end
  always @(posedge clk) begin
    med_pipe[0] <= med9(wa);
    for (int i = 1; i < LAT; i++) med_pipe[i] <= med_pipe[i-1];
  end
  assign med_in = med_pipe[LAT-1];

  // Reference filter result for frame position (r,c), taken from the image.
  function automatic logic [7:0] exp_at(input int r, input int c);
    logic [7:0] a [9];
    logic [7:0] m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) a[i*3+j] = img[r-1+i][c-1+j];
    m = med9(a);
`ifdef NOISE_GATE_EN
    if (img[r][c] != 8'h00 && img[r][c] != 8'hFF) m = img[r][c];
`endif
    return m;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h at cycle %0d, required none", out_pixel, cyc);
      end else begin
        e = sb.pop_front();
        if (out_pixel !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL out_pixel: got %h at cycle %0d, required %h at cycle %0d", out_pixel, cyc, e.val, e.cyc);
        end
      end
      got.push_back(out_pixel);
      out_cnt++;
      last_out_cyc = cyc;
    end
    if (frame_done) begin done_cnt++; done_cyc = cyc; end
    if (frame_abort) begin abort_cnt++; abort_cyc = cyc; end
  end

  task automatic chk(input string name, input int unsigned g, input int unsigned x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, g, x);
    end
  endtask

  task automatic check_reset(input string name);
    logic [85:0] v;
    v = {in_ready, win_px0, win_px1, win_px2, win_px3, win_px4, win_px5, win_px6,
         win_px7, win_px8, win_valid, sort_en, out_valid, out_pixel, frame_done, frame_abort};
    checks++;
    if (v !== {1'b1, 85'b0}) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, v, {1'b1, 85'b0});
    end
  endtask

  task automatic fill_img(input int unsigned pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0: img[r][c] = 8'(10 * r + c);
          1: img[r][c] = (r == 1 && c == 1) ? 8'hFF : 8'h80;
          default: img[r][c] = (r == 2 && c == 2) ? 8'h41 : 8'h40;
        endcase
  endtask

  task automatic clear_counts();
    out_cnt = 0; done_cnt = 0; abort_cnt = 0;
    last_out_cyc = 0; done_cyc = 0; abort_cyc = 0;
    got.delete(); sb.delete();
  endtask

  task automatic send_px(input logic [7:0] p, input logic s, input int r, input int c,
                         input bit push, output int unsigned dcyc);
    int unsigned n = 0;
    in_valid = 1'b1; in_pixel = p; in_sof = s;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", in_ready, 1);
    dcyc = cyc;
    if (push && r >= 2 && c >= 2) sb.push_back('{exp_at(r - 1, c - 1), cyc + 13});
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit gap, input bit push);
    int unsigned d;
    for (int i = lo; i < hi; i++) begin
      send_px(img[i / W][i % W], i == 0, i / W, i % W, push, d);
      if (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_frame(input int unsigned n_exp);
    int unsigned n = 0;
    while (done_cnt == 0 && n < 300) begin @(posedge clk); #1; n++; end
    repeat (4) @(posedge clk);
    #1;
    chk("frame_done_count", done_cnt, 1);
    chk("frame_done_timing", done_cyc, last_out_cyc + 1);
    chk("out_count", out_cnt, n_exp);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    int unsigned d, ob;
    vecs[0] = '{0, 1'b0, 6, 4, 8'd22};
    vecs[1] = '{0, 1'b1, 6, 5, 8'd23};
    vecs[2] = '{1, 1'b0, 6, 0, 8'h80};
    vecs[3] = '{2, 1'b0, 6, 4, P3};

    nres = 1'b0; in_valid = 1'b0; in_pixel = '0; in_sof = 1'b0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_values");
    nres = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      fill_img(vecs[v].pat);
      clear_counts();
      send_range(0, W * H, vecs[v].gap, 1'b1);
      wait_frame(vecs[v].n_out);
      if (got.size() > vecs[v].pidx) chk($sformatf("probe_v%0d", v), got[vecs[v].pidx], vecs[v].pval);
      else chk($sformatf("probe_v%0d_present", v), got.size(), vecs[v].pidx + 1);
      if (vecs[v].pat == 0 && got.size() == 6)
        for (int i = 0; i < 6; i++) chk($sformatf("ramp_v%0d_%0d", v, i), got[i], ramp_exp[i]);
    end

    // Restart mid-frame: in_sof on what would have been (2,3).
    fill_img(0);
    clear_counts();
    send_range(0, 2 * W + 3, 1'b0, 1'b0);
    send_px(img[0][0], 1'b1, 0, 0, 1'b1, d);
    send_range(1, W * H, 1'b0, 1'b1);
    wait_frame(6);
    chk("abort_count", abort_cnt, 1);
    chk("abort_timing", abort_cyc, d + 2);
    if (got.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("ramp_abort_%0d", i), got[i], ramp_exp[i]);

    // Reset while draining.
    clear_counts();
    send_range(0, W * H, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_in_ready", in_ready, 0);
    chk("drain_sort_en", sort_en, 1);
    nres = 1'b0;
    #1;
    check_reset("reset_in_drain");
    sb.delete();
    ob = out_cnt;
    @(posedge clk); #1;
    nres = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, 0);
    chk("no_out_after_reset", out_cnt, ob);
    chk("no_abort_after_reset", abort_cnt, 0);
    clear_counts();
    send_range(0, W * H, 1'b0, 1'b1);
    wait_frame(6);
    if (got.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("ramp_post_reset_%0d", i), got[i], ramp_exp[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
